muldiv_sequencer: RTL and testbench

Iterative RISC-V M-extension execution unit controller. It accepts one MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU request through a valid/ready handshake and sequences a shared shift-add/restoring-subtract datapath over XLEN iterations. It returns the result through a second valid/ready handshake. It sits beside the integer ALU in the execute stage and takes ops that the ALU controller does not decode.

---
 rtl/riscv_m_pkg.sv | 40 ++++
 rtl/muldiv_iter_dp.sv | 71 +++++++
 rtl/muldiv_sequencer.sv | 177 +++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_m_pkg.sv
// riscv_m_pkg
// Shared definitions for the RISC-V M-extension iterative unit:
//   - funct3 encodings for the eight M-extension ops
//   - muldiv_state_t, the sequencer state encoding
//   - decode helpers: is_div, op1_signed, op2_signed
package riscv_m_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ITER,
        FIXUP,
        DONE
    } muldiv_state_t;

    // All divide/remainder ops have funct3[2] set.
    function automatic logic is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

    function automatic logic op1_signed(input logic [2:0] f3);
        return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
               (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic op2_signed(input logic [2:0] f3);
        return (f3 == F3_MUL) || (f3 == F3_MULH) ||
               (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/muldiv_iter_dp.sv
// muldiv_iter_dp
// Shared unsigned shift-add multiply / restoring divide datapath.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   load            capture operand magnitudes and clear the accumulator
//   step            perform one iteration (one product bit or quotient bit)
//   div_mode        1 = restoring divide, 0 = shift-add multiply
//   mag_a, mag_b    unsigned operand magnitudes (multiplier/dividend, multiplicand/divisor)
//   acc             multiply: product high half; divide: remainder
//   sr              multiply: product low half;  divide: quotient
module muldiv_iter_dp #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            step,
    input  logic            div_mode,
    input  logic [XLEN-1:0] mag_a,
    input  logic [XLEN-1:0] mag_b,
    output logic [XLEN-1:0] acc,
    output logic [XLEN-1:0] sr
);

    logic [XLEN-1:0] md;
    logic [XLEN:0]   add_sum;
    logic [XLEN:0]   shifted;
    logic [XLEN+1:0] trial;
    logic            unused_bits;

    // Next-step arithmetic for both modes. The multiply adds the multiplicand
    // into the high half when the current multiplier bit is set; the divide
    // shifts the next dividend bit into the partial remainder and trial-subtracts.
    // The remainder always fits in XLEN bits, so the top bits of shifted/trial
    // are only needed for the borrow decision.
    always_comb begin
        add_sum = {1'b0, acc} + (sr[0] ? {1'b0, md} : {(XLEN+1){1'b0}});
        shifted = {acc, sr[XLEN-1]};
        trial   = {1'b0, shifted} - {2'b00, md};
    end

    assign unused_bits = ^{shifted[XLEN], trial[XLEN]};

    // Accumulator and shift register. The product is formed in {acc, sr}
    // shifting right; the quotient is built in sr shifting left.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            sr  <= '0;
            md  <= '0;
        end else if (load) begin
            acc <= '0;
            sr  <= mag_a;
            md  <= mag_b;
        end else if (step) begin
            if (div_mode) begin
                if (!trial[XLEN+1]) begin
                    acc <= trial[XLEN-1:0];
                    sr  <= {sr[XLEN-2:0], 1'b1};
                end else begin
                    acc <= shifted[XLEN-1:0];
                    sr  <= {sr[XLEN-2:0], 1'b0};
                end
            end else begin
                acc <= add_sum[XLEN:1];
                sr  <= {add_sum[0], sr[XLEN-1:1]};
            end
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
// Iterative RISC-V M-extension execution unit controller. Accepts one op
// through req_valid/req_ready, runs XLEN iterations on muldiv_iter_dp,
// applies the sign fixup and returns the result through resp_valid/resp_ready.
// Ports:
//   clk, rst_n               clock, async active-low reset
//   flush                    synchronous abort of any in-flight op
//   req_valid, req_ready     request handshake
//   funct3, rs1, rs2, tag    op encoding, operands, destination tag
//   resp_valid, resp_ready   response handshake
//   resp_data, resp_tag      result and echoed tag (registered)
//   busy                     registered, high whenever state != IDLE
module muldiv_sequencer
    import riscv_m_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int TAGW = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [TAGW-1:0] tag,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic [TAGW-1:0] resp_tag,
    output logic            busy
);

    localparam int CNTW = $clog2(XLEN) + 1;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_state_t     state;
    logic [CNTW-1:0]   cnt;
    logic [2:0]        f3_q;
    logic [TAGW-1:0]   tag_q;
    logic [XLEN-1:0]   op_a;
    logic [XLEN-1:0]   op_b;
    logic              neg_q;

    logic              sign_a, sign_b, neg_next;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic              div_zero, div_ovf;
    logic [XLEN-1:0]   short_result;
    logic [XLEN-1:0]   dp_acc, dp_sr;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix, rem_fix, result;

    assign req_ready = (state == IDLE) && !flush;

    // Operand signedness, magnitudes and short-circuit detection, all from
    // the operands latched at accept. Remainders take the dividend's sign;
    // products and quotients are negative when exactly one operand is.
    always_comb begin
        sign_a   = op1_signed(f3_q) & op_a[XLEN-1];
        sign_b   = op2_signed(f3_q) & op_b[XLEN-1];
        mag_a    = sign_a ? -op_a : op_a;
        mag_b    = sign_b ? -op_b : op_b;
        neg_next = (is_div(f3_q) && f3_q[1]) ? sign_a : (sign_a ^ sign_b);
        div_zero = is_div(f3_q) && (op_b == '0);
        div_ovf  = ((f3_q == F3_DIV) || (f3_q == F3_REM)) &&
                   (op_a == MIN_NEG) && (op_b == '1);
        short_result = '0;
        if (div_zero) begin
            short_result = f3_q[1] ? op_a : '1;
        end else if (div_ovf) begin
            short_result = f3_q[1] ? '0 : op_a;
        end
    end

    // Sign fixup and result selection. A negative product is negated across
    // the full 2*XLEN width so the high half picks up the borrow correctly.
    always_comb begin
        prod_fix = neg_q ? -{dp_acc, dp_sr} : {dp_acc, dp_sr};
        quot_fix = neg_q ? -dp_sr : dp_sr;
        rem_fix  = neg_q ? -dp_acc : dp_acc;
        result   = '0;
        if (is_div(f3_q)) begin
            result = f3_q[1] ? rem_fix : quot_fix;
        end else if (f3_q == F3_MUL) begin
            result = prod_fix[XLEN-1:0];
        end else begin
            result = prod_fix[2*XLEN-1:XLEN];
        end
    end

    muldiv_iter_dp #(
        .XLEN(XLEN)
    ) u_dp (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (state == SETUP),
        .step    (state == ITER),
        .div_mode(is_div(f3_q)),
        .mag_a   (mag_a),
        .mag_b   (mag_b),
        .acc     (dp_acc),
        .sr      (dp_sr)
    );

    // Control FSM with registered handshake outputs. flush overrides every
    // state and drops any pending response without issuing it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            f3_q       <= '0;
            tag_q      <= '0;
            op_a       <= '0;
            op_b       <= '0;
            neg_q      <= 1'b0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_tag   <= '0;
            busy       <= 1'b0;
        end else if (flush) begin
            state      <= IDLE;
            cnt        <= '0;
            resp_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        f3_q  <= funct3;
                        tag_q <= tag;
                        op_a  <= rs1;
                        op_b  <= rs2;
                        busy  <= 1'b1;
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    neg_q <= neg_next;
                    cnt   <= '0;
                    if (div_zero || div_ovf) begin
                        resp_data  <= short_result;
                        resp_tag   <= tag_q;
                        resp_valid <= 1'b1;
                        state      <= DONE;
                    end else begin
                        state <= ITER;
                    end
                end
                ITER: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        state <= FIXUP;
                    end
                end
                FIXUP: begin
                    resp_data  <= result;
                    resp_tag   <= tag_q;
                    resp_valid <= 1'b1;
                    state      <= DONE;
                end
                DONE: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer
// Scoreboard bench for muldiv_sequencer: expected results (data, tag,
// latency) are pushed when a request is driven and popped when the
// response appears.
module tb_muldiv_sequencer;

    localparam int XLEN = 32;
    localparam int TAGW = 5;
    localparam int LAT_FULL  = XLEN + 2;
    localparam int LAT_SHORT = 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            flush;
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1, rs2;
    logic [TAGW-1:0] tag;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_data;
    logic [TAGW-1:0] resp_tag;
    logic            busy;

    typedef struct {
        logic [XLEN-1:0] data;
        logic [TAGW-1:0] tag;
        int              lat;
    } exp_t;

    exp_t scoreboard[$];
    int   checks = 0;
    int   errors = 0;

    muldiv_sequencer #(.XLEN(XLEN), .TAGW(TAGW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .funct3    (funct3),
        .rs1       (rs1),
        .rs2       (rs2),
        .tag       (tag),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_data (resp_data),
        .resp_tag  (resp_tag),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference model built on 64-bit arithmetic.
    function automatic logic [31:0] ref_data(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint     sa, sbv, ua, ub;
        logic [63:0] pv;
        logic       ovf;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        ua  = longint'({32'b0, a});
        ub  = longint'({32'b0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        pv  = '0;
        case (f3)
            3'b000: begin pv = sa * sbv; return pv[31:0]; end
            3'b001: begin pv = sa * sbv; return pv[63:32]; end
            3'b010: begin pv = sa * ub;  return pv[63:32]; end
            3'b011: begin pv = ua * ub;  return pv[63:32]; end
            3'b100: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                pv = sa / sbv; return pv[31:0];
            end
            3'b101: begin
                if (b == 0) return 32'hFFFF_FFFF;
                pv = ua / ub; return pv[31:0];
            end
            3'b110: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                pv = sa % sbv; return pv[31:0];
            end
            default: begin
                if (b == 0) return a;
                pv = ua % ub; return pv[31:0];
            end
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3[2] && ((b == 0) || ((f3 == 3'b100 || f3 == 3'b110) &&
                      a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return LAT_SHORT;
        return LAT_FULL;
    endfunction

    // Drive one request for a cycle; returns #1 after the accepting edge.
    task automatic send_req(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                            input logic [TAGW-1:0] t, input bit track);
        exp_t e;
        @(negedge clk);
        funct3 = f3; rs1 = a; rs2 = b; tag = t; req_valid = 1'b1;
        if (track) begin
            e.data = ref_data(f3, a, b);
            e.tag  = t;
            e.lat  = ref_lat(f3, a, b);
            scoreboard.push_back(e);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    // Count edges after the accepting edge until resp_valid, bounded.
    task automatic wait_resp(output int lat, output bit timed_out);
        lat = 0;
        @(negedge clk);
        while (!resp_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        timed_out = !resp_valid;
    endtask

    task automatic release_resp();
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
        funct3 = '0; rs1 = '0; rs2 = '0; tag = '0;
        #12;
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_resp_valid got %b want 0", resp_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        checks++; if (resp_data !== '0) begin errors++; $display("[TB] FAIL reset_resp_data got %h want 0", resp_data); end
        checks++; if (resp_tag !== '0) begin errors++; $display("[TB] FAIL reset_resp_tag got %h want 0", resp_tag); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_req_ready got %b want 1", req_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_busy got %b want 0", busy); end
    endtask

    task automatic test_mul();
        logic [2:0]  f3s[4] = '{3'b000, 3'b011, 3'b001, 3'b010};
        logic [31:0] as[4]  = '{32'd7, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
        logic [31:0] bs[4]  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
        logic [31:0] want[4] = '{32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'h4000_0000, 32'hFFFF_FFFF};
        exp_t e;
        int   lat;
        bit   to;
        for (int i = 0; i < 4; i++) begin
            send_req(f3s[i], as[i], bs[i], TAGW'(5 + i), 1'b1);
            wait_resp(lat, to);
            e = scoreboard.pop_front();
            checks++;
            if (to) begin
                errors++; $display("[TB] FAIL mul_timeout op %0d got no resp_valid want resp_valid", i);
            end else begin
                if (resp_data !== e.data) begin errors++; $display("[TB] FAIL mul_data op %0d got %h want %h", i, resp_data, e.data); end
                checks++; if (resp_data !== want[i]) begin errors++; $display("[TB] FAIL mul_table op %0d got %h want %h", i, resp_data, want[i]); end
                checks++; if (resp_tag !== e.tag) begin errors++; $display("[TB] FAIL mul_tag op %0d got %0d want %0d", i, resp_tag, e.tag); end
                checks++; if (lat != e.lat) begin errors++; $display("[TB] FAIL mul_latency op %0d got %0d want %0d", i, lat, e.lat); end
            end
            release_resp();
        end
    endtask

    task automatic test_div();
        logic [2:0]  f3s[8] = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b101, 3'b110, 3'b100, 3'b110};
        logic [31:0] as[8]  = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100, 32'd5, 32'd5,
                                32'h8000_0000, 32'h8000_0000};
        logic [31:0] bs[8]  = '{32'd2, 32'd2, 32'd7, 32'd7, 32'd0, 32'd0,
                                32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] want[8] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5,
                                 32'h8000_0000, 32'h0};
        exp_t e;
        int   lat;
        bit   to;
        for (int i = 0; i < 8; i++) begin
            send_req(f3s[i], as[i], bs[i], TAGW'(16 + i), 1'b1);
            wait_resp(lat, to);
            e = scoreboard.pop_front();
            checks++;
            if (to) begin
                errors++; $display("[TB] FAIL div_timeout op %0d got no resp_valid want resp_valid", i);
            end else begin
                if (resp_data !== e.data) begin errors++; $display("[TB] FAIL div_data op %0d got %h want %h", i, resp_data, e.data); end
                checks++; if (resp_data !== want[i]) begin errors++; $display("[TB] FAIL div_table op %0d got %h want %h", i, resp_data, want[i]); end
                checks++; if (resp_tag !== e.tag) begin errors++; $display("[TB] FAIL div_tag op %0d got %0d want %0d", i, resp_tag, e.tag); end
                checks++; if (lat != e.lat) begin errors++; $display("[TB] FAIL div_latency op %0d got %0d want %0d", i, lat, e.lat); end
            end
            release_resp();
        end
    endtask

    task automatic test_random();
        exp_t        e;
        int          lat;
        bit          to;
        logic [2:0]  f3;
        logic [31:0] a, b;
        for (int i = 0; i < 16; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom;
            send_req(f3, a, b, TAGW'($urandom), 1'b1);
            wait_resp(lat, to);
            e = scoreboard.pop_front();
            checks++;
            if (to) begin
                errors++; $display("[TB] FAIL rand_timeout op %0d got no resp_valid want resp_valid", i);
            end else begin
                if (resp_data !== e.data) begin errors++; $display("[TB] FAIL rand_data f3 %0d a %h b %h got %h want %h", f3, a, b, resp_data, e.data); end
                checks++; if (resp_tag !== e.tag) begin errors++; $display("[TB] FAIL rand_tag op %0d got %0d want %0d", i, resp_tag, e.tag); end
                checks++; if (lat != e.lat) begin errors++; $display("[TB] FAIL rand_latency op %0d got %0d want %0d", i, lat, e.lat); end
            end
            release_resp();
        end
    endtask

    task automatic test_flush();
        bit seen = 1'b0;
        send_req(3'b101, 32'd1000, 32'd3, 5'd3, 1'b0);
        // Edges 1..11 leave ITER with counter 10; flush during that cycle.
        repeat (12) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL flush_busy_before got %b want 1", busy); end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL flush_busy_after got %b want 0", busy); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL flush_req_ready got %b want 1", req_ready); end
        // A request held while flush is high must not be accepted.
        flush = 1'b1; req_valid = 1'b1; funct3 = 3'b000; rs1 = 32'd3; rs2 = 32'd4;
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("[TB] FAIL flush_blocks_ready got %b want 0", req_ready); end
        repeat (2) @(negedge clk);
        flush = 1'b0; req_valid = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL flush_no_accept busy got %b want 0", busy); end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (resp_valid) seen = 1'b1;
        end
        checks++; if (seen) begin errors++; $display("[TB] FAIL flush_no_response got resp_valid 1 want 0"); end
    endtask

    task automatic test_async_reset();
        bit seen = 1'b0;
        send_req(3'b000, 32'd12345, 32'd678, 5'd21, 1'b0);
        repeat (15) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL areset_busy_before got %b want 1", busy); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL areset_busy got %b want 0", busy); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL areset_resp_valid got %b want 0", resp_valid); end
        checks++; if (resp_data !== '0) begin errors++; $display("[TB] FAIL areset_resp_data got %h want 0", resp_data); end
        checks++; if (resp_tag !== '0) begin errors++; $display("[TB] FAIL areset_resp_tag got %h want 0", resp_tag); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL areset_req_ready got %b want 1", req_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (resp_valid || busy) seen = 1'b1;
        end
        checks++; if (seen) begin errors++; $display("[TB] FAIL areset_abandon got activity want none"); end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   lat;
        bit   to;
        send_req(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, 1'b1);
        wait_resp(lat, to);
        e = scoreboard.pop_front();
        checks++;
        if (to) begin
            errors++; $display("[TB] FAIL hold_timeout got no resp_valid want resp_valid");
        end
        for (int i = 0; i < 5; i++) begin
            checks++; if (resp_valid !== 1'b1) begin errors++; $display("[TB] FAIL hold_valid cyc %0d got %b want 1", i, resp_valid); end
            checks++; if (resp_data !== e.data) begin errors++; $display("[TB] FAIL hold_data cyc %0d got %h want %h", i, resp_data, e.data); end
            checks++; if (resp_tag !== e.tag) begin errors++; $display("[TB] FAIL hold_tag cyc %0d got %0d want %0d", i, resp_tag, e.tag); end
            checks++; if (req_ready !== 1'b0) begin errors++; $display("[TB] FAIL hold_req_ready cyc %0d got %b want 0", i, req_ready); end
            @(negedge clk);
        end
        release_resp();
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL release_valid got %b want 0", resp_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL release_busy got %b want 0", busy); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL release_req_ready got %b want 1", req_ready); end
        send_req(3'b101, 32'd100, 32'd7, 5'd10, 1'b1);
        wait_resp(lat, to);
        e = scoreboard.pop_front();
        checks++;
        if (to) begin
            errors++; $display("[TB] FAIL b2b_timeout got no resp_valid want resp_valid");
        end else begin
            if (resp_data !== e.data) begin errors++; $display("[TB] FAIL b2b_data got %h want %h", resp_data, e.data); end
            checks++; if (resp_tag !== e.tag) begin errors++; $display("[TB] FAIL b2b_tag got %0d want %0d", resp_tag, e.tag); end
            checks++; if (lat != e.lat) begin errors++; $display("[TB] FAIL b2b_latency got %0d want %0d", lat, e.lat); end
        end
        release_resp();
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_mul();
        test_async_reset();
        test_div();
        test_random();
        test_flush();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
